// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised Moore sequence detector.
// Holds the state-width helper, the default pattern and the elaboration-time
// prefix-function helper used to build the transition constants.
package seq_det_pkg;

    // Longest supported pattern; also the working width of pattern helpers.
    localparam int MAX_PAT_LEN = 16;

    // Pattern of the original fixed detector (first bit received is the MSB).
    localparam logic [MAX_PAT_LEN-1:0] DEFAULT_PATTERN = 16'b1010;

    // Bits needed to encode states S0..S{pat_len}.
    function automatic int state_w(input int pat_len);
        return $clog2(pat_len + 1);
    endfunction

    // Bit p of the pattern in reception order (p = 0 is the first bit received).
    function automatic logic pat_bit(input logic [MAX_PAT_LEN-1:0] pat,
                                     input int pat_len, input int p);
        logic [MAX_PAT_LEN-1:0] sh;
        sh = pat >> (pat_len - 1 - p);
        return sh[0];
    endfunction

    // Successor of state k on input b: the longest j such that the j-bit
    // suffix of (first k pattern bits, then b) equals the first j pattern
    // bits. Called with k = pat_len for overlapping fallback after a detect.
    // Only ever evaluated with constant arguments, so it folds to constants.
    function automatic int next_state(input int k, input logic b,
                                      input logic [MAX_PAT_LEN-1:0] pat,
                                      input int pat_len);
        int   best;
        int   p;
        logic ok;
        logic s_bit;
        best = 0;
        for (int j = 1; j <= MAX_PAT_LEN; j++) begin
            if (j <= k + 1 && j <= pat_len) begin
                ok = 1'b1;
                for (int t = 0; t < MAX_PAT_LEN; t++) begin
                    if (t < j) begin
                        p     = k + 1 - j + t;
                        s_bit = (p < k) ? pat_bit(pat, pat_len, p) : b;
                        if (s_bit != pat_bit(pat, pat_len, t)) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = j;
                end
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seq_det_counter.sv
// Saturating detection counter for the sequence detector.
// Counts one per cycle where both en and inc are high, sticks at all-ones,
// and clears only on the asynchronous active-low reset.
module seq_det_counter
    import seq_det_pkg::*;
#(
    parameter int W = 8
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

    // Saturating increment; holds once the maximum value is reached.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (en && inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_moore_param.sv
// Parametrised Moore serial pattern detector.
// State Sk means the last k sampled bits equal the first k pattern bits;
// S{PAT_LEN} is the detect state and drives out. Transitions are folded to
// constants at elaboration from PATTERN, so no runtime table lookup exists.
// Optional feature: define SEQ_DET_CNT_EN to add the saturating match_cnt
// output; without it the counter and the port are absent.
module seq_detector_moore_param
    import seq_det_pkg::*;
#(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(DEFAULT_PATTERN),
    parameter bit                 OVERLAP = 1'b1,
    parameter int                 CNT_W   = 8,
    localparam int                SW      = state_w(PAT_LEN)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             en,
    output logic             out,
    output logic [SW-1:0]    state_o
`ifdef SEQ_DET_CNT_EN
    ,
    output logic [CNT_W-1:0] match_cnt
`endif
);

    // Elaboration guards on the configuration.
    if (PAT_LEN < 2 || PAT_LEN > MAX_PAT_LEN) begin : g_bad_pat_len
        $error("seq_detector_moore_param: PAT_LEN must be in 2..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_detector_moore_param: CNT_W must be at least 1");
    end

    localparam logic [MAX_PAT_LEN-1:0] PAT16 = MAX_PAT_LEN'(PATTERN);
    localparam logic [SW-1:0]          S_DET = SW'(PAT_LEN);

    logic [SW-1:0] state;
    logic [SW-1:0] state_nxt;

    // Successor constants for each state on input 0 and input 1.
    logic [SW-1:0] nxt0 [PAT_LEN+1];
    logic [SW-1:0] nxt1 [PAT_LEN+1];

    for (genvar k = 0; k <= PAT_LEN; k++) begin : g_trans
        // From the detect state a non-overlapping detector restarts as if
        // from S0; an overlapping one falls back through the prefix function.
        localparam int KS = (k == PAT_LEN && !OVERLAP) ? 0 : k;
        localparam logic [SW-1:0] N0 = SW'(next_state(KS, 1'b0, PAT16, PAT_LEN));
        localparam logic [SW-1:0] N1 = SW'(next_state(KS, 1'b1, PAT16, PAT_LEN));
        assign nxt0[k] = N0;
        assign nxt1[k] = N1;
    end

    // State register: async clear, advances only on enabled samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= '0;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // Next-state selection from the elaboration-time transition constants;
    // unreachable encodings fall back to S0.
    always_comb begin
        state_nxt = '0;
        for (int k = 0; k <= PAT_LEN; k++) begin
            if (state == SW'(k)) begin
                state_nxt = in ? nxt1[k] : nxt0[k];
            end
        end
    end

    // Moore output: decoded from the registered state only.
    always_comb begin
        out     = (state == S_DET);
        state_o = state;
    end

`ifdef SEQ_DET_CNT_EN
    // Every enabled sample that lands in the detect state is one detection,
    // including back-to-back re-detections.
    seq_det_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .inc (state_nxt == S_DET),
        .cnt (match_cnt)
    );
`endif

endmodule
